// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Receiver FSM states, legal prescale values and parity encoding shared with the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Anything outside the legal set runs at the slowest-oversampling rate of 8.
  function automatic logic [5:0] eff_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver line, configuration and result bundle
// master drives the line and configuration; slave is the receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            PRESCALE;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    output P_DATA, Data_Valid, Par_Err, Stp_Err
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - three-point capture and majority vote per bit
// sampled_bit_o is valid from the cycle where edge_cnt_i reaches half_i + 2.
module uart_rx_sampler (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       active_i,
  input  logic       rx_i,
  input  logic [5:0] edge_cnt_i,
  input  logic [5:0] half_i,
  output logic       sampled_bit_o
);

  logic s0_q;
  logic s1_q;
  logic bit_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
      bit_q <= 1'b1;
    end else if (active_i) begin
      if (edge_cnt_i == half_i - 6'd1) s0_q <= rx_i;
      if (edge_cnt_i == half_i)        s1_q <= rx_i;
      // Third sample is taken live and voted in the same edge.
      if (edge_cnt_i == half_i + 6'd1)
        bit_q <= (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
    end
  end

  assign sampled_bit_o = bit_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with optional parity
// Frame: start 0, data LSB first, optional parity, stop 1; strobes are registered one-cycle pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave bus
);
  import uart_pkg::*;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e             state_q;
  logic [5:0]            edge_cnt_q;
  logic [3:0]            bit_cnt_q;
  logic [5:0]            p_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_fail_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  dv_q;
  logic                  pe_q;
  logic                  se_q;

  logic [5:0] half;
  logic       wrap;
  logic       at_check;
  logic       sampled_bit;
  logic       exp_par;

  assign half     = {1'b0, p_q[5:1]};
  assign wrap     = (edge_cnt_q == p_q - 6'd1);
  assign at_check = (edge_cnt_q == half + 6'd2);
  assign exp_par  = (^shift_q) ^ (par_typ_q == PAR_ODD);

  uart_rx_sampler u_sampler (
    .clk_i         (CLK),
    .rstn_i        (RST),
    .active_i      (state_q != IDLE),
    .rx_i          (bus.RX_IN),
    .edge_cnt_i    (edge_cnt_q),
    .half_i        (half),
    .sampled_bit_o (sampled_bit)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      p_q        <= PRESCALE_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      shift_q    <= '0;
      par_fail_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
      if (state_q != IDLE) begin
        edge_cnt_q <= wrap ? 6'd0 : edge_cnt_q + 6'd1;
        if (wrap) bit_cnt_q <= bit_cnt_q + 4'd1;
      end
      case (state_q)
        IDLE: begin
          if (!bus.RX_IN) begin
            state_q    <= START;
            p_q        <= eff_prescale(bus.PRESCALE);
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            par_fail_q <= 1'b0;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end
        START: begin
          if (at_check && sampled_bit) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end else if (wrap) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (at_check) shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (wrap && bit_cnt_q == LAST_DATA_BIT) state_q <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (at_check) par_fail_q <= (sampled_bit != exp_par);
          if (wrap) state_q <= STOP;
        end
        STOP: begin
          // Leave early so a back-to-back start bit is seen by IDLE.
          if (at_check) begin
            se_q <= ~sampled_bit;
            pe_q <= par_fail_q;
            if (sampled_bit && !par_fail_q) begin
              p_data_q <= shift_q;
              dv_q     <= 1'b1;
            end
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = dv_q;
  assign bus.Par_Err    = pe_q;
  assign bus.Stp_Err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  logic clk;
  logic rst;
  int   cyc;
  int   start_cyc;
  int   n_checks;
  int   n_pass;
  int   dv_n, pe_n, se_n;
  int   dv_lat, pe_lat, se_lat;
  logic [7:0] rx_mem [0:7];

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.Data_Valid === 1'b1) begin
      rx_mem[dv_n % 8] = bus.P_DATA;
      dv_n   = dv_n + 1;
      dv_lat = cyc - start_cyc;
    end
    if (bus.Par_Err === 1'b1) begin
      pe_n   = pe_n + 1;
      pe_lat = cyc - start_cyc;
    end
    if (bus.Stp_Err === 1'b1) begin
      se_n   = se_n + 1;
      se_lat = cyc - start_cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_counts();
    dv_n = 0; pe_n = 0; se_n = 0;
    dv_lat = -1; pe_lat = -1; se_lat = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.RX_IN = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic v, input int p, input int noise_j);
    for (int j = 0; j < p; j++) begin
      @(negedge clk);
      bus.RX_IN = (j == noise_j) ? ~v : v;
    end
  endtask

  // noise_bit selects the frame bit (0 = start) whose middle sample is inverted.
  task automatic send_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                            input logic stop_bit, input int p, input int noise_bit);
    for (int j = 0; j < p; j++) begin
      @(negedge clk);
      bus.RX_IN = 1'b0;
      if (j == 0) start_cyc = cyc + 1;
    end
    for (int b = 0; b < 8; b++)
      drive_bit(data[b], p, (noise_bit == b + 1) ? p / 2 + 1 : -1);
    if (with_par) drive_bit(par_bit, p, -1);
    drive_bit(stop_bit, p, -1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    start_cyc = 0;
    clear_counts();
    rst          = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.PRESCALE = 6'd8;
    repeat (3) @(negedge clk);
    check("rst_p_data", 32'(bus.P_DATA), 32'h00);
    check("rst_dv", 32'(bus.Data_Valid), 32'h0);
    check("rst_pe", 32'(bus.Par_Err), 32'h0);
    check("rst_se", 32'(bus.Stp_Err), 32'h0);
    rst = 1'b1;
    idle(4);

    clear_counts();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, -1);
    idle(6);
    check("a5_dv_count", 32'(dv_n), 32'd1);
    check("a5_latency", 32'(dv_lat), 32'd79);
    check("a5_byte", 32'(rx_mem[0]), 32'hA5);
    check("a5_errs", 32'(pe_n + se_n), 32'd0);
    check("a5_held", 32'(bus.P_DATA), 32'hA5);

    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    clear_counts();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 8, -1);
    idle(6);
    check("5a_even_dv", 32'(dv_n), 32'd1);
    check("5a_even_lat", 32'(dv_lat), 32'd87);
    check("5a_even_byte", 32'(rx_mem[0]), 32'h5A);
    check("5a_even_errs", 32'(pe_n + se_n), 32'd0);

    clear_counts();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 8, -1);
    idle(6);
    check("5a_bad_pe", 32'(pe_n), 32'd1);
    check("5a_bad_pe_lat", 32'(pe_lat), 32'd87);
    check("5a_bad_dv", 32'(dv_n), 32'd0);
    check("5a_bad_se", 32'(se_n), 32'd0);
    check("5a_bad_held", 32'(bus.P_DATA), 32'h5A);

    bus.PAR_TYP = 1'b1;
    clear_counts();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 8, -1);
    idle(6);
    check("3c_se", 32'(se_n), 32'd1);
    check("3c_se_lat", 32'(se_lat), 32'd87);
    check("3c_pe", 32'(pe_n), 32'd0);
    check("3c_dv", 32'(dv_n), 32'd0);
    check("3c_held", 32'(bus.P_DATA), 32'h5A);

    bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    clear_counts();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.RX_IN = 1'b0;
    end
    idle(20);
    check("glitch_pulses", 32'(dv_n + pe_n + se_n), 32'd0);
    check("glitch_held", 32'(bus.P_DATA), 32'h5A);

    bus.PRESCALE = 6'd16;
    clear_counts();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16, -1);
    idle(10);
    check("p16_dv", 32'(dv_n), 32'd1);
    check("p16_lat", 32'(dv_lat), 32'd155);
    check("p16_byte", 32'(rx_mem[0]), 32'h81);

    bus.PRESCALE = 6'd12;
    clear_counts();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8, -1);
    idle(6);
    check("p12_lat", 32'(dv_lat), 32'd79);
    check("p12_byte", 32'(rx_mem[0]), 32'hC3);

    bus.PRESCALE = 6'd8;
    clear_counts();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 8, 3);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8, 3);
    idle(6);
    check("b2b_dv", 32'(dv_n), 32'd2);
    check("b2b_first", 32'(rx_mem[0]), 32'h00);
    check("b2b_second", 32'(rx_mem[1]), 32'hFF);
    check("b2b_errs", 32'(pe_n + se_n), 32'd0);

    clear_counts();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      bus.RX_IN = 1'b0;
    end
    for (int b = 0; b < 4; b++) drive_bit(1'b1, 8, -1);
    drive_bit(1'b1, 3, -1);
    @(negedge clk);
    rst = 1'b0;
    bus.RX_IN = 1'b1;
    @(negedge clk);
    check("abort_p_data", 32'(bus.P_DATA), 32'h00);
    check("abort_strobes", 32'({bus.Data_Valid, bus.Par_Err, bus.Stp_Err}), 32'h0);
    rst = 1'b1;
    idle(100);
    check("abort_no_pulse", 32'(dv_n + pe_n + se_n), 32'd0);

    clear_counts();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 8, -1);
    idle(6);
    check("post_abort_dv", 32'(dv_n), 32'd1);
    check("post_abort_lat", 32'(dv_lat), 32'd79);
    check("post_abort_byte", 32'(bus.P_DATA), 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the `UART_TX` stage: it consumes the `TX_OUT` line, oversamples it, and recovers 8-bit frames with optional even/odd parity. It delivers each good byte with a one-cycle `Data_Valid` strobe and flags parity and stop-bit errors. Frame format matches the transmitter: start 0, `P_DATA[0]` first through `P_DATA[7]`, optional parity bit, stop 1.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `CLK` input 1: single clock; all logic on the rising edge.
- `RST` input 1: synchronous, active-low reset.
- `RX_IN` input 1: serial line. Synchronous to `CLK`; there is no internal synchronizer. Idle level is 1.
- `PAR_EN` input 1: 1 means a parity bit follows the data.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd.
- `PRESCALE` input 6: `CLK` cycles per bit. Legal values are 8, 16 and 32; any other value behaves as 8.
- `P_DATA` output `DATA_WIDTH`: last good byte, held between frames.
- `Data_Valid` output 1: one-cycle pulse when a frame arrives with no errors.
- `Par_Err` output 1: one-cycle pulse at frame end when the parity check fails.
- `Stp_Err` output 1: one-cycle pulse at frame end when the stop bit is sampled as 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- In every non-IDLE state:
  - `edge_cnt` runs 0..P−1, where P is the effective prescale.
  - `bit_cnt` advances when `edge_cnt` wraps.
- IDLE:
  - When `RX_IN`=0 is sampled, go to START. That clock edge counts as `edge_cnt`=0 of the start bit.
  - `PAR_EN`, `PAR_TYP` and `PRESCALE` are latched at this edge. Changes mid-frame are ignored.
- Sampling:
  - `RX_IN` is captured at `edge_cnt` = P/2−1, P/2 and P/2+1.
  - The majority-of-3 result, `sampled_bit`, is registered. It is valid when `edge_cnt` = P/2+2.
- START: if `sampled_bit`=1, the event is a glitch. Return to IDLE with no output and no error. Otherwise go to DATA at the wrap.
- DATA:
  - Shift `sampled_bit` in LSB-first.
  - After 8 bits, go to PARITY if `PAR_EN`=1, else to STOP.
- PARITY: the expected bit is XOR of all data bits, XOR `PAR_TYP`. A mismatch sets an internal `par_fail`.
- STOP: at `edge_cnt`=P/2+2, with `sampled_bit` valid, do the following on that edge:
  - If `sampled_bit`=0, pulse `Stp_Err`.
  - If `par_fail`, pulse `Par_Err`.
  - If neither error, load `P_DATA` and pulse `Data_Valid`.
  - Return to IDLE. The rest of the stop bit is spent in IDLE, so a back-to-back start bit is detected.
- A frame with any error leaves `P_DATA` unchanged.
- `Par_Err` and `Stp_Err` may pulse in the same cycle.

## Timing
- Reset values:
  - State is IDLE and all counters are 0.
  - `P_DATA`=0; `Data_Valid`, `Par_Err` and `Stp_Err` are 0.
- `RST` low mid-frame aborts the frame on the next edge. No strobe is produced.
- Latency: the error/valid pulses are visible N cycles after the edge at which IDLE first sampled `RX_IN`=0.
  - Without parity: N = 9·P + P/2 + 3.
  - With parity: N = 10·P + P/2 + 3.
  - At P=8 this gives 79 and 87.
- Outputs are registered. Every strobe is exactly one cycle wide.
- The next start bit can be accepted no earlier than 1 cycle after the strobe.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - `PRESCALE` legal-value constants;
  - the parity-type encoding (`PAR_EVEN`=0, `PAR_ODD`=1), shared with `UART_TX`.
- Sub-module `uart_rx_sampler`: sample capture and majority vote, driven by `edge_cnt` and P. It outputs `sampled_bit`.
- The top level holds the FSM, counters, deserializer and the checks.

## Test plan
- All tests use P=8 with `RX_IN` driven directly unless stated.
- 8'hA5, `PAR_EN`=0 → `Data_Valid` pulses 79 cycles after the start edge; `P_DATA`=8'hA5; no errors.
- 8'h5A, even parity, parity bit 0 → `Data_Valid` at 87 cycles, `P_DATA`=8'h5A. Repeat with parity bit forced to 1 → `Par_Err` pulse, no `Data_Valid`, `P_DATA` still 8'h5A.
- 8'h3C, odd parity, parity bit 1, stop bit forced to 0 → `Stp_Err` pulse, no `Data_Valid`, `P_DATA` unchanged.
- 3-cycle low glitch on idle `RX_IN` → FSM returns to IDLE, no pulses. Then 8'h81 at P=16 → `Data_Valid` at 9·16+8+3 = 155 cycles.
- Two back-to-back frames, 8'h00 then 8'hFF, with no idle gap; single-sample noise inverting `RX_IN` at `edge_cnt`=P/2 of bit 3 → both bytes received intact.
- `RST` low during data bit 4 → outputs 0 on the next edge, no strobe. A subsequent frame of 8'h12 is received correctly.
